// File: rtl/ky_dma_arb.sv
// Round-robin arbiter and sequencer that shares the single Unibus DMA cycle engine
// between NREQ FPGA-side requesters, with optional RMW hold and ARM back-off.
module ky_dma_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned HOLDMAX = 1000
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               init_in_h,
    input  logic [31:0]        dmalock,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [2*NREQ-1:0]  ctrl,
    input  logic [18*NREQ-1:0] addr,
    input  logic [16*NREQ-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [15:0]        rdata,
    output logic               timo,
    output logic               perr,
    output logic               eng_start,
    output logic [1:0]         eng_ctrl,
    output logic [17:0]        eng_addr,
    output logic [15:0]        eng_wdata,
    input  logic               eng_busy,
    input  logic               eng_done,
    input  logic               eng_timo,
    input  logic               eng_perr,
    input  logic [15:0]        eng_rdata
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(HOLDMAX + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [1:0]      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [CW-1:0]   hold_cnt;

    logic [PW-1:0]   win_idx;
    logic            win_found;
    logic [PW-1:0]   cand_idx;
    logic [PW-1:0]   sel_idx;
    logic [1:0]      sel_ctrl;
    logic [17:0]     sel_addr;
    logic [15:0]     sel_wdata;
    logic [NREQ-1:0] owner_hot;
    logic [PW-1:0]   ptr_after;
    logic            owner_req;
    logic            owner_lock;
    logic            arm_owns;

    assign owner_hot  = ONE << owner;
    assign owner_req  = |(req & owner_hot);
    assign owner_lock = |(lock & owner_hot);
    assign arm_owns   = (dmalock != 32'd0);
    assign ptr_after  = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign eng_start  = (state == ST_ISSUE) && !init_in_h;

    // First set request at ptr, ptr+1, ... wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_idx = PW'((32'(ptr) + 32'(i)) % NREQ);
            if (!win_found && |(req & (ONE << cand_idx))) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_idx   = (state == ST_IDLE) ? win_idx : owner;
        sel_ctrl  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == PW'(i)) begin
                sel_ctrl  = ctrl[2*i +: 2];
                sel_addr  = addr[18*i +: 18];
                sel_wdata = wdata[16*i +: 16];
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            owner     <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            timo      <= 1'b0;
            perr      <= 1'b0;
            eng_ctrl  <= '0;
            eng_addr  <= '0;
            eng_wdata <= '0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (!init_in_h && !arm_owns && !eng_busy && win_found) begin
                        owner     <= win_idx;
                        gnt       <= ONE << win_idx;
                        eng_ctrl  <= sel_ctrl;
                        eng_addr  <= sel_addr;
                        eng_wdata <= sel_wdata;
                        state     <= ST_ISSUE;
                    end else begin
                        gnt <= '0;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (init_in_h) begin
                        // Abort: report to owner as a timed-out cycle, keep rdata and ptr.
                        done  <= owner_hot;
                        timo  <= 1'b1;
                        perr  <= 1'b0;
                        gnt   <= '0;
                        state <= ST_IDLE;
                    end else if (state == ST_ISSUE) begin
                        state <= ST_WAIT;
                    end else if (eng_done) begin
                        done  <= owner_hot;
                        rdata <= eng_rdata;
                        timo  <= eng_timo;
                        perr  <= eng_perr;
                        if (owner_lock && !eng_timo && !arm_owns) begin
                            hold_cnt <= '0;
                            state    <= ST_HOLD;
                        end else begin
                            gnt   <= '0;
                            ptr   <= ptr_after;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (init_in_h) begin
                        gnt   <= '0;
                        state <= ST_IDLE;
                    end else if (owner_req && owner_lock) begin
                        eng_ctrl  <= sel_ctrl;
                        eng_addr  <= sel_addr;
                        eng_wdata <= sel_wdata;
                        hold_cnt  <= '0;
                        state     <= ST_ISSUE;
                    end else if (!owner_lock || hold_cnt == CW'(HOLDMAX - 1) || arm_owns) begin
                        gnt   <= '0;
                        ptr   <= ptr_after;
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
